// File: rtl/cache_pkg.sv
// Shared cache geometry defaults and serializer state encoding.
package cache_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_SIZE       = 512;
    localparam int NUM_SEGMENTS     = 16;
    localparam int NUM_SEGMENTS_LOG = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/block_serializer_word_select.sv
// block_word_select: combinational mux picking one word of a cache block by offset.
module block_word_select #(
    parameter int WORD_SIZE        = cache_pkg::WORD_SIZE,
    parameter int NUM_SEGMENTS     = cache_pkg::NUM_SEGMENTS,
    parameter int NUM_SEGMENTS_LOG = cache_pkg::NUM_SEGMENTS_LOG
) (
    input  logic [WORD_SIZE*NUM_SEGMENTS-1:0] block_i,
    input  logic [NUM_SEGMENTS_LOG-1:0]       offset_i,
    output logic [WORD_SIZE-1:0]              word_o
);

    logic [NUM_SEGMENTS-1:0][WORD_SIZE-1:0] words;

    assign words  = block_i;
    assign word_o = words[offset_i];

endmodule

// File: rtl/block_serializer.sv
// block_serializer: drains a captured cache block as a valid/ready word stream.
// Define BLOCK_SERIALIZER_WRAP_EN to add start_offset (critical-word-first order).
module block_serializer
    import cache_pkg::*;
#(
    parameter int WORD_SIZE        = cache_pkg::WORD_SIZE,
    parameter int BLOCK_SIZE       = cache_pkg::BLOCK_SIZE,
    parameter int NUM_SEGMENTS     = cache_pkg::NUM_SEGMENTS,
    parameter int NUM_SEGMENTS_LOG = cache_pkg::NUM_SEGMENTS_LOG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [BLOCK_SIZE-1:0]       block_in,
`ifdef BLOCK_SERIALIZER_WRAP_EN
    input  logic [NUM_SEGMENTS_LOG-1:0] start_offset,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_SIZE-1:0]        out_data,
    output logic [NUM_SEGMENTS_LOG-1:0] out_offset,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam logic [NUM_SEGMENTS_LOG:0] CNT_LAST = (NUM_SEGMENTS_LOG+1)'(NUM_SEGMENTS - 1);

    state_e                        state_q;
    logic [BLOCK_SIZE-1:0]         blk_q;
    logic [NUM_SEGMENTS_LOG-1:0]   offset_q;
    logic [NUM_SEGMENTS_LOG:0]     count_q;
    logic                          out_valid_q;
    logic                          out_last_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          start_ready_q;

    logic [NUM_SEGMENTS_LOG-1:0]   first_offset_d;
    logic [NUM_SEGMENTS_LOG:0]     count_d;

`ifdef BLOCK_SERIALIZER_WRAP_EN
    assign first_offset_d = start_offset;
`else
    assign first_offset_d = '0;
`endif

    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            blk_q         <= '0;
            offset_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        state_q       <= SEND;
                        blk_q         <= block_in;
                        offset_q      <= first_offset_d;
                        count_q       <= '0;
                        out_valid_q   <= 1'b1;
                        out_last_q    <= (NUM_SEGMENTS == 1);
                        busy_q        <= 1'b1;
                        start_ready_q <= 1'b0;
                    end
                end
                SEND: begin
                    // Outputs only move on a handshake so a stalled word stays stable.
                    if (out_ready) begin
                        offset_q <= offset_q + 1'b1;
                        count_q  <= count_d;
                        if (out_last_q) begin
                            state_q       <= IDLE;
                            out_valid_q   <= 1'b0;
                            out_last_q    <= 1'b0;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            start_ready_q <= 1'b1;
                        end else begin
                            out_last_q <= (count_d == CNT_LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    block_word_select #(
        .WORD_SIZE        (WORD_SIZE),
        .NUM_SEGMENTS     (NUM_SEGMENTS),
        .NUM_SEGMENTS_LOG (NUM_SEGMENTS_LOG)
    ) u_word_select (
        .block_i  (blk_q),
        .offset_i (offset_q),
        .word_o   (out_data)
    );

    assign out_offset  = offset_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign start_ready = start_ready_q;

endmodule

// File: tb/tb_block_serializer.sv
// Randomized directed bench for block_serializer against an offset/word reference model.
module tb_block_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [511:0] block_in;
    logic [3:0]   start_offset;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [3:0]   out_offset;
    logic         out_last;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    block_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .block_in    (block_in),
`ifdef BLOCK_SERIALIZER_WRAP_EN
        .start_offset(start_offset),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_offset  (out_offset),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // mode 0: ready always, 1: pattern 1,0,0,1, 2: random. abort_at<0 disables reset abort.
    task automatic run_xfer(input logic [511:0] blk, input logic [3:0] soff, input int mode,
                            input bit inject, input int abort_at, output int cycles);
        int  k;
        int  cyc;
        int  exp_off;
        bit  fin;
        bit  rdy;
        @(negedge clk);
        chk("start_ready_idle", start_ready, 1);
        block_in     = blk;
        start_offset = soff;
        start_valid  = 1'b1;
        out_ready    = 1'b0;
        @(negedge clk);
        start_valid = inject;
        if (inject) block_in = rand_block();
        k   = 0;
        cyc = 1;
        fin = 0;
        while (!fin && cyc < 400) begin
            exp_off = (soff + k) % 16;
            chk("out_valid", out_valid, 1);
            chk("out_offset", out_offset, exp_off);
            chk("out_data", out_data, blk[exp_off*32 +: 32]);
            chk("out_last", out_last, (k == 15));
            chk("busy", busy, 1);
            chk("start_ready_send", start_ready, 0);
            chk("done_send", done, 0);
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1'b1;
                start_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_start_ready", start_ready, 1);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                @(negedge clk);
                chk("abort_no_done", done, 0);
                chk("abort_idle_valid", out_valid, 0);
                fin = 1;
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                out_ready = rdy;
                if (rdy && k == 15) begin
                    start_valid = 1'b0;
                    @(negedge clk);
                    cyc++;
                    chk("done_pulse", done, 1);
                    chk("end_out_valid", out_valid, 0);
                    chk("end_out_last", out_last, 0);
                    chk("end_busy", busy, 0);
                    chk("end_start_ready", start_ready, 1);
                    out_ready = 1'b0;
                    @(negedge clk);
                    chk("done_once", done, 0);
                    fin = 1;
                end else begin
                    if (rdy) k++;
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        out_ready   = 1'b0;
        start_valid = 1'b0;
        cycles      = cyc;
    endtask

    initial begin
        logic [511:0] blk;
        int           cycles;

        rst          = 1'b1;
        start_valid  = 1'b0;
        out_ready    = 1'b0;
        block_in     = '0;
        start_offset = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_out_last", out_last, 0);
        rst = 1'b0;

        // Counting pattern, ready tied high; done lands N+NUM_SEGMENTS+1.
        for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'hA000_0000 + i;
        run_xfer(blk, 4'd0, 0, 1'b0, -1, cycles);
        chk("drain_latency", cycles, 17);

        // Backpressure 1,0,0,1.
        run_xfer(rand_block(), 4'd0, 1, 1'b0, -1, cycles);

        // Random backpressure on several blocks.
        for (int n = 0; n < 3; n++) run_xfer(rand_block(), 4'd0, 2, 1'b0, -1, cycles);

        // New start offered during SEND must be ignored.
        run_xfer(rand_block(), 4'd0, 2, 1'b1, -1, cycles);

        // Reset at the 5th word, then a fresh full block from offset 0.
        run_xfer(rand_block(), 4'd0, 0, 1'b0, 4, cycles);
        run_xfer(rand_block(), 4'd0, 0, 1'b0, -1, cycles);
        chk("post_abort_latency", cycles, 17);

`ifdef BLOCK_SERIALIZER_WRAP_EN
        run_xfer(rand_block(), 4'd13, 0, 1'b0, -1, cycles);
        run_xfer(rand_block(), 4'($urandom_range(0, 15)), 2, 1'b0, -1, cycles);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
